pattern_seq_trigger: RTL
========================

PATTERN_SEQ_TRIGGER -- requirements
Module: pattern_seq_trigger

Interface
REQ-001 SHALL have parameter DW, default 8: width of the sampled data bus and of each pattern/mask register.
REQ-002 SHALL have parameter AW, default 2: slot index width; number of pattern slots NSLOT = 2**AW.
REQ-003 SHALL have parameter CW, default 8: width of the timeout value and of the hit counter.
REQ-004 SHALL have ports, clock and reset first:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- CFG_WE  in  1  configuration write strobe.
- CFG_SEL  in  1  write target: 0 = pattern register, 1 = mask register.
- ABUS  in  AW  slot index for the configuration write.
- DBUS  in  DW  configuration write data.
- SDATA  in  DW  sampled data to compare.
- SVALID  in  1  SDATA is valid this cycle.
- ARM  in  1  level; enables the search.
- MODE  in  1  0 = single-shot, 1 = continuous re-arm.
- STAGES  in  AW+1  number of sequence stages in use.
- TMO  in  CW  inter-stage timeout in cycles; 0 = disabled.
- WREN  out  1  one-cycle pulse when the full sequence matches.
- BUSY  out  1  high while in SEARCH.
- STAGE  out  AW  current stage index.
- HIT_CNT  out  CW  saturating count of completed sequences.

Function
REQ-005 SHALL hold NSLOT pattern registers PAT[k] and NSLOT mask registers MASK[k], each DW bits wide.
REQ-006 SHALL write DBUS into PAT[ABUS] (CFG_SEL=0) or MASK[ABUS] (CFG_SEL=1) on a cycle with CFG_WE=1; the new value is used for compares from the next cycle, and a same-cycle compare uses the old value.
REQ-007 SHALL define match(k) as ((SDATA XOR PAT[k]) AND NOT MASK[k]) == 0; a MASK bit of 1 means "don't care".
REQ-008 SHALL compute the effective stage count N = 1 when STAGES = 0, N = NSLOT when STAGES > NSLOT, otherwise N = STAGES.
REQ-009 SHALL implement the state machine IDLE, SEARCH, DONE as follows.
- IDLE: with ARM=1, go to SEARCH next cycle with STAGE=0.
- SEARCH: with ARM=0, go to IDLE, STAGE=0, no WREN; ARM=0 has priority over every other event.
- SEARCH: with SVALID=1 and match(STAGE) and STAGE < N-1, increment STAGE and clear the timer.
- SEARCH: with SVALID=1 and match(STAGE) and STAGE = N-1, assert WREN in the next cycle and increment HIT_CNT. MODE=1 then sets STAGE=0 and stays in SEARCH; MODE=0 goes to DONE.
- SEARCH: a non-matching or invalid sample leaves STAGE unchanged.
- DONE: BUSY=0; hold until ARM=0, then go to IDLE.
REQ-010 SHALL, in SEARCH with STAGE > 0 and TMO != 0, count cycles since the last stage advance; when the count reaches TMO, set STAGE=0. A match in the same cycle wins over the timeout.
REQ-011 SHALL register WREN: a final-stage match sampled at edge n gives WREN=1 for exactly the cycle after edge n. Back-to-back matches in MODE=1 give consecutive pulses.
REQ-012 SHALL saturate HIT_CNT at 2**CW-1; only RST clears it.
REQ-013 SHALL drive BUSY=1 exactly while in SEARCH.
REQ-014 SHALL not alter the stage or state because of a configuration write during SEARCH.

Reset
REQ-015 SHALL, on RST=1 at a clock edge, set:
- state = IDLE, STAGE = 0, timer = 0;
- WREN = 0, BUSY = 0, HIT_CNT = 0;
- every PAT and every MASK = 0.
REQ-016 SHALL give RST priority over ARM, CFG_WE and an in-progress match, including a reset arriving mid-sequence.

Verification (DW=8, AW=2, CW=8)
REQ-017 Reset: RST for 2 cycles -> WREN=0, BUSY=0, STAGE=0, HIT_CNT=0; SDATA=0x00 with STAGES=1, ARM=1 matches PAT0=0 and gives WREN.
REQ-018 Sequence: PAT0=0xA5, PAT1=0x5A, STAGES=2, MODE=0, ARM=1; feed 0xA5, 0x00, 0x5A -> one WREN pulse one cycle after 0x5A, HIT_CNT=1, BUSY=0 (DONE).
REQ-019 Mask: PAT0=0xA0, MASK0=0x0F, STAGES=1; 0xAF -> WREN pulse; 0xB0 -> no WREN.
REQ-020 Timeout: TMO=3, two-stage sequence; match stage 0, then 3 idle cycles -> STAGE returns to 0; a following 0x5A -> no WREN.
REQ-021 Saturation: MODE=1, STAGES=1, PAT0=0x11, 300 consecutive valid 0x11 samples -> 300 WREN pulses, HIT_CNT=255.
REQ-022 Abort: ARM deasserted in the same cycle as the final-stage match -> no WREN, state IDLE, HIT_CNT unchanged.

Source files
------------

// File: rtl/pattern_seq_trigger.sv
// Multi-stage masked pattern sequencer: fires a registered WREN pulse when
// SDATA matches PAT/MASK slots 0..N-1 in order, with an optional inter-stage timeout.
module pattern_seq_trigger #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CFG_WE,
  input  logic          CFG_SEL,
  input  logic [AW-1:0] ABUS,
  input  logic [DW-1:0] DBUS,
  input  logic [DW-1:0] SDATA,
  input  logic          SVALID,
  input  logic          ARM,
  input  logic          MODE,
  input  logic [AW:0]   STAGES,
  input  logic [CW-1:0] TMO,
  output logic          WREN,
  output logic          BUSY,
  output logic [AW-1:0] STAGE,
  output logic [CW-1:0] HIT_CNT
);
  localparam int NSLOT = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            stage_q, stage_d, last_stage;
  logic [CW-1:0]            timer_q, timer_d, timer_inc;
  logic [CW-1:0]            hit_q, hit_d;
  logic                     wren_q, wren_d;
  logic [NSLOT-1:0][DW-1:0] pat_q, mask_q;
  logic [NSLOT-1:0]         match_vec;
  logic                     cur_match;

  // Per-slot compare against the registered (pre-write) pattern and mask.
  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    assign match_vec[k] = ~|((SDATA ^ pat_q[k]) & ~mask_q[k]);
  end

  assign cur_match = SVALID & match_vec[stage_q];
  assign timer_inc = timer_q + CW'(1);

  // STAGES[AW] set means STAGES >= NSLOT, so the last stage clamps to NSLOT-1.
  always_comb begin
    if (STAGES == '0)    last_stage = '0;
    else if (STAGES[AW]) last_stage = '1;
    else                 last_stage = STAGES[AW-1:0] - AW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q  <= '0;
      mask_q <= '0;
    end else if (CFG_WE) begin
      if (CFG_SEL) mask_q[ABUS] <= DBUS;
      else         pat_q[ABUS]  <= DBUS;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      timer_q <= '0;
      hit_q   <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      timer_q <= timer_d;
      hit_q   <= hit_d;
      wren_q  <= wren_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    timer_d = timer_q;
    hit_d   = hit_q;
    wren_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stage_d = '0;
        timer_d = '0;
        if (ARM) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (!ARM) begin
          state_d = S_IDLE;
          stage_d = '0;
          timer_d = '0;
        end else if (cur_match) begin
          timer_d = '0;
          if (stage_q == last_stage) begin
            wren_d  = 1'b1;
            stage_d = '0;
            if (hit_q != '1) hit_d = hit_q + CW'(1);
            if (!MODE) state_d = S_DONE;
          end else begin
            stage_d = stage_q + AW'(1);
          end
        end else if (stage_q != '0 && TMO != '0) begin
          // Timeout only applies once at least one stage has matched.
          if (timer_inc == TMO) begin
            stage_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_DONE: begin
        if (!ARM) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign WREN    = wren_q;
  assign BUSY    = (state_q == S_SEARCH);
  assign STAGE   = stage_q;
  assign HIT_CNT = hit_q;
endmodule
